// File: rtl/isqrt_pipe_with_valid_if.sv
// Operand/result bundle for the pipelined integer square root.
// The master issues operands; the slave returns floor(sqrt(x)) n_stages cycles later.
interface isqrt_pipe_with_valid_if #(
  parameter int width = 32
);
  logic                 x_vld;
  logic [width-1:0]     x;
  logic                 y_vld;
  logic [width/2-1:0]   y;

  modport master (output x_vld, output x, input y_vld, input y);
  modport slave  (input x_vld, input x, output y_vld, output y);
endinterface

// File: rtl/isqrt_pipe_with_valid.sv
// Fully pipelined floor(sqrt(x)), restoring digit-by-digit, one root bit per stage.
// A valid bit travels with each operand; no stalls, fixed latency of width/2 cycles.
module isqrt_pipe_with_valid #(
  parameter int width = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  isqrt_pipe_with_valid_if.slave    bus
);
  localparam int n_stages = width / 2;
  localparam int rw       = n_stages + 2;

  logic                 vld_r     [n_stages];
  logic [rw-1:0]        rem_r     [n_stages];
  logic [n_stages-1:0]  root_r    [n_stages];
  logic [width-1:0]     op_r      [n_stages];

  logic                 vld_in_s  [n_stages];
  logic [rw-1:0]        rem_in_s  [n_stages];
  logic [n_stages-1:0]  root_in_s [n_stages];
  logic [width-1:0]     op_in_s   [n_stages];

  logic [rw-1:0]        rem_sh_s  [n_stages];
  logic [rw-1:0]        trial_s   [n_stages];
  logic [rw-1:0]        rem_nx_s  [n_stages];
  logic [n_stages-1:0]  root_nx_s [n_stages];
  logic [width-1:0]     op_nx_s   [n_stages];

  // Stage 0 starts from an empty remainder and root; later stages chain off their predecessor.
  assign vld_in_s[0]  = bus.x_vld;
  assign rem_in_s[0]  = '0;
  assign root_in_s[0] = '0;
  assign op_in_s[0]   = bus.x;

  for (genvar k = 1; k < n_stages; k++) begin : g_link
    assign vld_in_s[k]  = vld_r[k-1];
    assign rem_in_s[k]  = rem_r[k-1];
    assign root_in_s[k] = root_r[k-1];
    assign op_in_s[k]   = op_r[k-1];
  end

  // Per-stage restoring step: bring down two operand bits, try subtracting 4*root+1.
  always_comb begin
    for (int k = 0; k < n_stages; k++) begin
      rem_sh_s[k] = rw'({rem_in_s[k], op_in_s[k][width-1 -: 2]});
      trial_s[k]  = {root_in_s[k], 2'b01};
      op_nx_s[k]  = {op_in_s[k][width-3:0], 2'b00};
      if (rem_sh_s[k] >= trial_s[k]) begin
        rem_nx_s[k]  = rem_sh_s[k] - trial_s[k];
        root_nx_s[k] = {root_in_s[k][n_stages-2:0], 1'b1};
      end else begin
        rem_nx_s[k]  = rem_sh_s[k];
        root_nx_s[k] = {root_in_s[k][n_stages-2:0], 1'b0};
      end
    end
  end

  // Pipeline registers advance every cycle; reset flushes every stage including in-flight operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < n_stages; k++) begin
        vld_r[k]  <= 1'b0;
        rem_r[k]  <= '0;
        root_r[k] <= '0;
        op_r[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < n_stages; k++) begin
        vld_r[k]  <= vld_in_s[k];
        rem_r[k]  <= rem_nx_s[k];
        root_r[k] <= root_nx_s[k];
        op_r[k]   <= op_nx_s[k];
      end
    end
  end

  assign bus.y_vld = vld_r[n_stages-1];
  assign bus.y     = root_r[n_stages-1];
endmodule

// File: tb/tb_isqrt_pipe_with_valid.sv
// Self-checking bench: width=32 and width=8 pipelines against a queue-based latency model
// whose root comes from a real-valued sqrt corrected by integer bounds.
module tb_isqrt_pipe_with_valid;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  isqrt_pipe_with_valid_if #(.width(32)) bus32 ();
  isqrt_pipe_with_valid_if #(.width(8))  bus8 ();

  isqrt_pipe_with_valid #(.width(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  isqrt_pipe_with_valid #(.width(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

  typedef struct { bit v; longint y; } ent_t;
  typedef struct { longint y; int c; } obs_t;

  ent_t q32[$];
  ent_t q8[$];
  ent_t exp32;
  ent_t exp8;
  obs_t obs32[$];
  obs_t obs8[$];
  int   cyc   = 0;
  bit   armed = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic longint ref_isqrt(input longint x);
    longint y;
    y = longint'($floor($sqrt(real'(x))));
    while (y * y > x) y--;
    while ((y + 1) * (y + 1) <= x) y++;
    return y;
  endfunction

  // Reference model: each edge pushes what was issued; reset invalidates everything in flight.
  always @(posedge clk) begin
    ent_t e;
    cyc++;
    if (rst) begin
      armed = 1'b1;
      foreach (q32[i]) q32[i].v = 1'b0;
      foreach (q8[i])  q8[i].v  = 1'b0;
      e.v = 1'b0; e.y = 0;
      q32.push_back(e);
      q8.push_back(e);
    end else begin
      e.v = bus32.x_vld; e.y = ref_isqrt(longint'(bus32.x));
      q32.push_back(e);
      e.v = bus8.x_vld;  e.y = ref_isqrt(longint'(bus8.x));
      q8.push_back(e);
    end
    while (q32.size() > 16) void'(q32.pop_front());
    while (q8.size() > 4)   void'(q8.pop_front());
    exp32 = q32[0];
    exp8  = q8[0];
  end

  // Compare every cycle on the falling edge and log valid results for the directed checks.
  always @(negedge clk) begin
    obs_t o;
    if (armed && !rst) begin
      check_eq("vld32", bus32.y_vld, exp32.v);
      if (exp32.v) check_eq("y32", bus32.y, exp32.y);
      check_eq("vld8", bus8.y_vld, exp8.v);
      if (exp8.v) check_eq("y8", bus8.y, exp8.y);
      if (bus32.y_vld === 1'b1) begin o.y = bus32.y; o.c = cyc; obs32.push_back(o); end
      if (bus8.y_vld === 1'b1)  begin o.y = bus8.y;  o.c = cyc; obs8.push_back(o);  end
    end
  end

  task automatic drive(input bit v32, input logic [31:0] x32, input bit v8, input logic [7:0] x8);
    bus32.x_vld = v32; bus32.x = x32;
    bus8.x_vld  = v8;  bus8.x  = x8;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 8'h0);
  endtask

  // Issue a burst on the 32-bit pipe with a valid mask and check results, order and latency.
  task automatic burst32(input string tag, input longint xs[], input bit vs[], input longint ys[]);
    int issue0;
    int k;
    obs32.delete();
    issue0 = cyc;
    foreach (xs[i]) drive(vs[i], xs[i][31:0], 1'b0, 8'h0);
    idle(20);
    check_eq({tag, "_count"}, obs32.size(), ys.size());
    k = 0;
    foreach (xs[i]) begin
      if (vs[i] && k < obs32.size()) begin
        check_eq({tag, "_y"}, obs32[k].y, ys[k]);
        check_eq({tag, "_lat"}, obs32[k].c - issue0, 16 + i);
        k++;
      end
    end
  endtask

  initial begin
    longint xs[];
    bit     vs[];
    longint ys[];
    int     i8;
    int     issue0;
    logic [31:0] xr;
    int     kk;

    bus32.x_vld = 1'b0; bus32.x = '0;
    bus8.x_vld  = 1'b0; bus8.x  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_vld32", bus32.y_vld, 1'b0);
    check_eq("rst_y32", bus32.y, 16'h0);
    check_eq("rst_vld8", bus8.y_vld, 1'b0);
    check_eq("rst_y8", bus8.y, 4'h0);

    xs = '{0};                          vs = '{1};        ys = '{0};
    burst32("zero", xs, vs, ys);
    xs = '{1, 15, 16, 17, 1000000};     vs = '{1,1,1,1,1}; ys = '{1, 3, 4, 4, 1000};
    burst32("stream", xs, vs, ys);
    xs = '{32'hFFFFFFFF, 32'hFFFE0001, 32'hFFFE0000}; vs = '{1,1,1}; ys = '{16'hFFFF, 16'hFFFF, 16'hFFFE};
    burst32("bound", xs, vs, ys);
    xs = '{4, 9, 25, 36, 49, 64};       vs = '{1,0,1,1,0,1}; ys = '{2, 5, 6, 8};
    burst32("bubble", xs, vs, ys);

    // Reset while eight operands are in flight; the operand presented during reset is dropped too.
    obs32.delete();
    for (int i = 0; i < 8; i++) drive(1'b1, 32'(1000 + i * 77), 1'b0, 8'h0);
    rst = 1'b1;
    drive(1'b1, 32'd99, 1'b0, 8'h0);
    rst = 1'b0;
    idle(20);
    check_eq("flush_count", obs32.size(), 0);
    obs32.delete();
    issue0 = cyc;
    drive(1'b1, 32'd144, 1'b0, 8'h0);
    idle(20);
    check_eq("after_rst_count", obs32.size(), 1);
    if (obs32.size() > 0) begin
      check_eq("after_rst_y", obs32[0].y, 12);
      check_eq("after_rst_lat", obs32[0].c - issue0, 16);
    end

    // Random 32-bit traffic alongside an exhaustive 8-bit sweep with random bubbles.
    obs8.delete();
    i8 = 0;
    for (int n = 0; n < 10000; n++) begin
      kk = int'($urandom_range(0, 65535));
      case ($urandom_range(0, 3))
        0: xr = $urandom;
        1: xr = 32'(kk * kk);
        2: xr = 32'(kk * kk) - 32'd1;
        default: xr = 32'($urandom_range(0, 300));
      endcase
      if (i8 < 256 && $urandom_range(0, 1) == 1) begin
        drive($urandom_range(0, 3) != 0, xr, 1'b1, 8'(i8));
        i8++;
      end else begin
        drive($urandom_range(0, 3) != 0, xr, 1'b0, 8'h0);
      end
    end
    idle(20);
    check_eq("sweep8_count", obs8.size(), 256);
    foreach (obs8[i]) check_eq("sweep8_y", obs8[i].y, ref_isqrt(longint'(i)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
